// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: four-stage radix-2 complex butterfly. Each transaction
// selects DIF or DIT and an optional divide-by-2, with rounding and saturation.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             input handshake; in_ready is combinational
//   in_mode, in_scale, in_tag     0=DIF/1=DIT, 1=halve results, sideband tag
//   a_*, b_*, w_*                 complex operands and twiddle (Q1.TW_W-1)
//   out_valid/out_ready           output handshake
//   out_tag, oa_*, ob_*, out_sat  registered result, tag, per-result clamp flag
//   sat_sticky, grow_sticky       block-floating-point flags, cleared by flag_clr
module fft_butterfly_r2 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 16,
  parameter int unsigned TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic                     in_scale,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic signed [DATA_W-1:0] oa_re,
  output logic signed [DATA_W-1:0] oa_im,
  output logic signed [DATA_W-1:0] ob_re,
  output logic signed [DATA_W-1:0] ob_im,
  output logic                     out_sat,
  output logic                     sat_sticky,
  output logic                     grow_sticky,
  input  logic                     flag_clr
);

  localparam int unsigned SW  = DATA_W + 1;         // A+B / A-B
  localparam int unsigned PW  = DATA_W + TW_W + 1;  // full complex product B*W
  localparam int unsigned TXW = DATA_W + 2;         // rounded DIT product T
  localparam int unsigned XW  = DATA_W + TW_W + 3;  // pre-shift results

  localparam logic signed [PW-1:0]     P_RND   = PW'(1) <<< (TW_W - 2);
  localparam logic signed [XW-1:0]     SAT_MAX = (XW'(1) <<< (DATA_W - 1)) - XW'(1);
  localparam logic signed [XW-1:0]     SAT_MIN = -(XW'(1) <<< (DATA_W - 1));
  localparam logic signed [DATA_W-1:0] GROW_P  = DATA_W'(1) <<< (DATA_W - 2);
  localparam logic signed [DATA_W-1:0] GROW_N  = -GROW_P;

  logic                     advance, out_xfer;
  logic                     s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  logic                     s1_mode_q, s2_mode_q, s3_mode_q;
  logic                     s1_scale_q, s2_scale_q, s3_scale_q;
  logic [TAG_W-1:0]         s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;
  logic signed [DATA_W-1:0] s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q;
  logic signed [TW_W-1:0]   s1_w_re_q, s1_w_im_q;
  logic signed [PW-1:0]     s2_u_re_q, s2_u_im_q, s2_u_re_d, s2_u_im_d;
  logic signed [SW-1:0]     s2_d_re_q, s2_d_im_q, s2_d_re_d, s2_d_im_d;
  logic signed [DATA_W-1:0] s2_a_re_q, s2_a_im_q;
  logic signed [TW_W-1:0]   s2_w_re_q, s2_w_im_q;
  logic signed [TXW-1:0]    t_re, t_im;
  // Result slots: 0 = A' re, 1 = A' im, 2 = B' re, 3 = B' im
  logic signed [XW-1:0]     s3_x_q [4];
  logic signed [XW-1:0]     s3_x_d [4];
  logic signed [DATA_W-1:0] out_q [4];
  logic signed [DATA_W-1:0] out_d [4];
  logic                     out_sat_q, out_sat_d;
  logic                     sat_sticky_q, sat_sticky_d, grow_sticky_q, grow_sticky_d;
  logic                     grow_c;

  // Round half toward +inf, then arithmetic shift by k
  function automatic logic signed [XW-1:0] rnd_shift(input logic signed [XW-1:0] x,
                                                     input int unsigned k);
    logic signed [XW-1:0] r;
    r = x;
    if (k != 0) r = (x + (XW'(1) <<< (k - 1))) >>> k;
    return r;
  endfunction

  // Single global stall: every stage moves together or not at all
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign out_xfer = out_valid_q && out_ready;

  // S2: DIF sum/difference, DIT complex product B*W
  always_comb begin
    s2_u_re_d = '0;
    s2_u_im_d = '0;
    s2_d_re_d = '0;
    s2_d_im_d = '0;
    if (s1_mode_q) begin
      s2_u_re_d = PW'(s1_b_re_q) * PW'(s1_w_re_q) - PW'(s1_b_im_q) * PW'(s1_w_im_q);
      s2_u_im_d = PW'(s1_b_re_q) * PW'(s1_w_im_q) + PW'(s1_b_im_q) * PW'(s1_w_re_q);
    end else begin
      s2_u_re_d = PW'(s1_a_re_q) + PW'(s1_b_re_q);
      s2_u_im_d = PW'(s1_a_im_q) + PW'(s1_b_im_q);
      s2_d_re_d = SW'(s1_a_re_q) - SW'(s1_b_re_q);
      s2_d_im_d = SW'(s1_a_im_q) - SW'(s1_b_im_q);
    end
  end

  // S3: DIF multiplies D by W; DIT rounds P to T and forms A +/- T
  always_comb begin
    t_re = TXW'((s2_u_re_q + P_RND) >>> (TW_W - 1));
    t_im = TXW'((s2_u_im_q + P_RND) >>> (TW_W - 1));
    for (int i = 0; i < 4; i++) s3_x_d[i] = '0;
    if (s2_mode_q) begin
      s3_x_d[0] = XW'(s2_a_re_q) + XW'(t_re);
      s3_x_d[1] = XW'(s2_a_im_q) + XW'(t_im);
      s3_x_d[2] = XW'(s2_a_re_q) - XW'(t_re);
      s3_x_d[3] = XW'(s2_a_im_q) - XW'(t_im);
    end else begin
      s3_x_d[0] = XW'(s2_u_re_q);
      s3_x_d[1] = XW'(s2_u_im_q);
      s3_x_d[2] = XW'(s2_d_re_q) * XW'(s2_w_re_q) - XW'(s2_d_im_q) * XW'(s2_w_im_q);
      s3_x_d[3] = XW'(s2_d_re_q) * XW'(s2_w_im_q) + XW'(s2_d_im_q) * XW'(s2_w_re_q);
    end
  end

  // S4: DIF B' still carries the twiddle's fractional bits
  always_comb begin
    int unsigned k_a, k_b;
    logic signed [XW-1:0] r;
    k_a = s3_scale_q ? 1 : 0;
    k_b = s3_mode_q ? k_a : (TW_W - 1 + k_a);
    out_sat_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = rnd_shift(s3_x_q[i], (i < 2) ? k_a : k_b);
      out_d[i] = DATA_W'(r);
      if (r > SAT_MAX) begin
        out_d[i]  = DATA_W'(SAT_MAX);
        out_sat_d = 1'b1;
      end else if (r < SAT_MIN) begin
        out_d[i]  = DATA_W'(SAT_MIN);
        out_sat_d = 1'b1;
      end
    end
  end

  // Growth detect on the presented result; flags a candidate for rescaling
  always_comb begin
    grow_c = 1'b0;
    for (int i = 0; i < 4; i++)
      if (out_q[i] >= GROW_P || out_q[i] <= GROW_N) grow_c = 1'b1;
  end

  // A set on the same cycle as flag_clr wins
  assign sat_sticky_d  = (sat_sticky_q  && !flag_clr) || (out_xfer && out_sat_q);
  assign grow_sticky_d = (grow_sticky_q && !flag_clr) || (out_xfer && grow_c);

  // Control, valids and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s3_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_sat_q     <= 1'b0;
      sat_sticky_q  <= 1'b0;
      grow_sticky_q <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      if (advance) begin
        s1_valid_q  <= in_valid;
        s2_valid_q  <= s1_valid_q;
        s3_valid_q  <= s2_valid_q;
        out_valid_q <= s3_valid_q;
        // Bubbles leave the last result on the outputs
        if (s3_valid_q) begin
          out_tag_q <= s3_tag_q;
          out_sat_q <= out_sat_d;
          for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
        end
      end
      sat_sticky_q  <= sat_sticky_d;
      grow_sticky_q <= grow_sticky_d;
    end
  end

  // Datapath registers, qualified by the valid pipeline
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_mode_q  <= in_mode;
      s1_scale_q <= in_scale;
      s1_tag_q   <= in_tag;
      s1_a_re_q  <= a_re;
      s1_a_im_q  <= a_im;
      s1_b_re_q  <= b_re;
      s1_b_im_q  <= b_im;
      s1_w_re_q  <= w_re;
      s1_w_im_q  <= w_im;
      s2_mode_q  <= s1_mode_q;
      s2_scale_q <= s1_scale_q;
      s2_tag_q   <= s1_tag_q;
      s2_u_re_q  <= s2_u_re_d;
      s2_u_im_q  <= s2_u_im_d;
      s2_d_re_q  <= s2_d_re_d;
      s2_d_im_q  <= s2_d_im_d;
      s2_a_re_q  <= s1_a_re_q;
      s2_a_im_q  <= s1_a_im_q;
      s2_w_re_q  <= s1_w_re_q;
      s2_w_im_q  <= s1_w_im_q;
      s3_mode_q  <= s2_mode_q;
      s3_scale_q <= s2_scale_q;
      s3_tag_q   <= s2_tag_q;
      for (int i = 0; i < 4; i++) s3_x_q[i] <= s3_x_d[i];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_tag     = out_tag_q;
  assign oa_re       = out_q[0];
  assign oa_im       = out_q[1];
  assign ob_re       = out_q[2];
  assign ob_im       = out_q[3];
  assign out_sat     = out_sat_q;
  assign sat_sticky  = sat_sticky_q;
  assign grow_sticky = grow_sticky_q;

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: directed vectors with hand-computed results for
// fft_butterfly_r2 (latency, rounding, saturation, sticky flags, backpressure,
// reset flush).
module tb_fft_butterfly_r2;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TW_W   = 16;
  localparam int unsigned TAG_W  = 8;

  logic                     clk, rst_n;
  logic                     in_valid, in_ready, in_mode, in_scale;
  logic [TAG_W-1:0]         in_tag;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic                     out_valid, out_ready;
  logic [TAG_W-1:0]         out_tag;
  logic signed [DATA_W-1:0] oa_re, oa_im, ob_re, ob_im;
  logic                     out_sat, sat_sticky, grow_sticky, flag_clr;

  fft_butterfly_r2 #(.DATA_W(DATA_W), .TW_W(TW_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_scale(in_scale),
    .in_tag(in_tag),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .oa_re(oa_re), .oa_im(oa_im), .ob_re(ob_re), .ob_im(ob_im),
    .out_sat(out_sat), .sat_sticky(sat_sticky), .grow_sticky(grow_sticky),
    .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    bit scale;
    int a_re, a_im, b_re, b_im, w_re, w_im;
    int oa_re, oa_im, ob_re, ob_im;
    bit sat;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int idx, input int tag);
    in_mode  = vecs[idx].mode;
    in_scale = vecs[idx].scale;
    in_tag   = TAG_W'(tag);
    a_re     = DATA_W'(vecs[idx].a_re);
    a_im     = DATA_W'(vecs[idx].a_im);
    b_re     = DATA_W'(vecs[idx].b_re);
    b_im     = DATA_W'(vecs[idx].b_im);
    w_re     = TW_W'(vecs[idx].w_re);
    w_im     = TW_W'(vecs[idx].w_im);
  endtask

  task automatic check_vec(input int idx, input int tag, input string pfx);
    check($sformatf("%s_v%0d_oa_re", pfx, idx), oa_re, vecs[idx].oa_re);
    check($sformatf("%s_v%0d_oa_im", pfx, idx), oa_im, vecs[idx].oa_im);
    check($sformatf("%s_v%0d_ob_re", pfx, idx), ob_re, vecs[idx].ob_re);
    check($sformatf("%s_v%0d_ob_im", pfx, idx), ob_im, vecs[idx].ob_im);
    check($sformatf("%s_v%0d_sat", pfx, idx), out_sat, vecs[idx].sat);
    check($sformatf("%s_v%0d_tag", pfx, idx), out_tag, tag);
  endtask

  // One transaction; returns with its result on the outputs, not yet taken
  task automatic run_single(input int idx, input int tag);
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    drive_vec(idx, tag);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check($sformatf("v%0d_lat_early", idx), out_valid, 0);
    tick();
    check($sformatf("v%0d_lat4_valid", idx), out_valid, 1);
    check_vec(idx, tag, "single");
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1'b0, 1'b0,  1000,     0,   200,     0,  32767,      0,   1200,     0,  800,      0, 1'b0};
    vecs[1] = '{1'b1, 1'b1,  1000,  -500,   300,   100,      0, -32768,    550,  -400,  450,   -100, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 30000,     0, 30000,     0,  32767,      0,  32767,     0,    0,      0, 1'b1};
    vecs[3] = '{1'b1, 1'b0,   100,   200,    10,    20, -32768,      0,     90,   180,  110,    220, 1'b0};
    vecs[4] = '{1'b0, 1'b1,     3,    -3,     0,     0,  32767,      0,      2,    -1,    1,     -1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32767,-32768, 32767, 32767,  32767,      0,  32767,    -2,    1, -32768, 1'b1};
    vecs[6] = '{1'b0, 1'b1,  -100,    50,  -300,   -50,      0,  32767,   -200,     0,  -50,    100, 1'b0};
    vecs[7] = '{1'b1, 1'b1,-20000, 20000,-20000, 20000,  32767,      0, -19999, 20000,    0,      1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    drive_vec(0, 0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_oa_re", oa_re, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_sat_sticky", sat_sticky, 0);
    check("rst_grow_sticky", grow_sticky, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Basic DIF / DIT / rounding / exact -1 twiddle
    run_single(0, 8'h11);
    run_single(1, 8'h22);
    check("sticky_sat_quiet", sat_sticky, 0);
    check("sticky_grow_quiet", grow_sticky, 0);
    run_single(3, 8'h33);
    run_single(4, 8'h44);

    // Saturation sets both flags; clear; set wins over a same-cycle clear
    run_single(2, 8'h55);
    tick();
    check("sticky_sat_set", sat_sticky, 1);
    check("sticky_grow_set", grow_sticky, 1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("sticky_sat_clr", sat_sticky, 0);
    check("sticky_grow_clr", grow_sticky, 0);
    run_single(2, 8'h56);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("sticky_sat_set_wins", sat_sticky, 1);
    check("sticky_grow_set_wins", grow_sticky, 1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("sticky_sat_clr2", sat_sticky, 0);

    // Back-to-back alternating modes with a 3-cycle output stall
    fork
      begin : drv
        int  i, guard;
        bit  rdy;
        i = 0;
        guard = 0;
        while (i < 8 && guard < 100) begin
          drive_vec(i, i);
          in_valid = 1'b1;
          @(negedge clk);
          rdy = in_ready;
          tick();
          guard++;
          if (rdy) i++;
        end
        in_valid = 1'b0;
        check("bp_all_in", i, 8);
      end
      begin : mon
        int n, cyc, stall;
        bit seen;
        n = 0; cyc = 0; stall = 0; seen = 1'b0;
        while (n < 8 && cyc < 100) begin
          if (out_valid && !seen) begin
            seen  = 1'b1;
            stall = 3;
          end
          out_ready = (stall == 0);
          #1;
          if (stall > 0) begin
            check($sformatf("bp_stall%0d_in_ready", stall), in_ready, 0);
            check($sformatf("bp_stall%0d_valid", stall), out_valid, 1);
            check($sformatf("bp_stall%0d_tag", stall), out_tag, 0);
            check($sformatf("bp_stall%0d_oa_re", stall), oa_re, vecs[0].oa_re);
            check($sformatf("bp_stall%0d_ob_re", stall), ob_re, vecs[0].ob_re);
            stall--;
          end else if (out_valid) begin
            check_vec(n, n, "bp");
            n++;
          end
          tick();
          cyc++;
        end
        check("bp_all_out", n, 8);
        out_ready = 1'b1;
      end
    join
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("bp_no_extra", cnt, 0);
    check("bp_sat_sticky", sat_sticky, 1);
    check("bp_grow_sticky", grow_sticky, 1);

    // Reset with three transactions in flight
    for (int k = 0; k < 3; k++) begin
      drive_vec(k, 8'h70 + k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst2_out_valid", out_valid, 0);
    check("rst2_oa_re", oa_re, 0);
    check("rst2_ob_re", ob_re, 0);
    check("rst2_out_tag", out_tag, 0);
    check("rst2_sat_sticky", sat_sticky, 0);
    check("rst2_grow_sticky", grow_sticky, 0);
    check("rst2_in_ready", in_ready, 1);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("rst2_flushed", cnt, 0);
    run_single(4, 8'h66);
    tick();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) cnt++;
      tick();
    end
    check("rst2_no_ghost", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
